// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the RV32I main decoder: opcode constants, ALUOp
// class encodings and the ctrl_t bundle carried from decode to the output
// register.
// -----------------------------------------------------------------------------
package control_pkg;

    localparam int OPCODE_W = 7;
    localparam int ALUOP_W  = 2;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    // ALU operation classes handed to the downstream ALU control block
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

    // All control outputs of the decoder, bundled
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               mem_to_reg;
        logic               jump;
        logic               illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '{
        alu_op:     ALUOP_ADD,
        reg_write:  1'b0,
        branch:     1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        jump:       1'b0,
        illegal:    1'b0
    };

endpackage

// File: rtl/control_decode.sv
// -----------------------------------------------------------------------------
// control_decode
// Purely combinational opcode decoder. Produces the full ctrl_t bundle from
// the opcode; a bubble (valid_in=0) yields an all-zero bundle.
// Ports:
//   valid_in  in   opcode carries a real instruction this cycle
//   opcode    in   instruction bits [6:0]
//   ctrl      out  decoded control bundle
// -----------------------------------------------------------------------------
module control_decode
    import control_pkg::*;
(
    input  logic                valid_in,
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    // Opcode to control-bundle decode; any unmatched (or X/Z) opcode falls
    // through to the default arm and is flagged illegal.
    always_comb begin
        ctrl = CTRL_ZERO;
        if (valid_in) begin
            case (opcode)
                OP_R: begin
                    ctrl.alu_op    = ALUOP_R;
                    ctrl.reg_write = 1'b1;
                end
                OP_IMM: begin
                    ctrl.alu_op    = ALUOP_I;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                end
                OP_LOAD: begin
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                OP_STORE: begin
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl.alu_op = ALUOP_BR;
                    ctrl.branch = 1'b1;
                end
                OP_JAL: begin
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.reg_write = 1'b1;
                    ctrl.jump      = 1'b1;
                end
                OP_JALR: begin
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.jump      = 1'b1;
                end
                OP_AUIPC, OP_LUI: begin
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                end
                default: begin
                    ctrl         = CTRL_ZERO;
                    ctrl.illegal = 1'b1;
                end
            endcase
        end else begin
            ctrl = CTRL_ZERO;
        end
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// RV32I main decoder with registered outputs (one cycle latency). Decoding is
// done in control_decode; this level holds the output register, cleared
// asynchronously by rst_n.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   opcode is a valid instruction this cycle
//   opcode     in   instruction bits [6:0]
//   ALUOp      out  ALU class (00 add, 01 branch cmp, 10 R funct, 11 I funct)
//   reg_write  out  write result to rd
//   branch     out  conditional branch
//   mem_read   out  data memory load
//   mem_write  out  data memory store
//   alu_src    out  1 = immediate operand B, 0 = rs2
//   mem_to_reg out  writeback from memory
//   jump       out  JAL/JALR
//   illegal    out  unknown opcode with valid_in=1
// -----------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                reg_write,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                jump,
    output logic                illegal
);

    ctrl_t ctrl_s;
    ctrl_t ctrl_r;

    control_decode u_decode (
        .valid_in (valid_in),
        .opcode   (opcode),
        .ctrl     (ctrl_s)
    );

    // Output register: captures the decoded bundle each edge, cleared at once by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= CTRL_ZERO;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign ALUOp      = ctrl_r.alu_op;
    assign reg_write  = ctrl_r.reg_write;
    assign branch     = ctrl_r.branch;
    assign mem_read   = ctrl_r.mem_read;
    assign mem_write  = ctrl_r.mem_write;
    assign alu_src    = ctrl_r.alu_src;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign jump       = ctrl_r.jump;
    assign illegal    = ctrl_r.illegal;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed and random checks of control_unit against a hand-written decode
// table. Output vector order: {ALUOp, reg_write, branch, mem_read, mem_write,
// alu_src, mem_to_reg, jump, illegal}.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [6:0] opcode;
    logic [1:0] ALUOp;
    logic       reg_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       jump;
    logic       illegal;

    int n_compared;
    int n_mismatched;

    logic [9:0] obs_s;
    assign obs_s = {ALUOp, reg_write, branch, mem_read, mem_write,
                    alu_src, mem_to_reg, jump, illegal};

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .ALUOp      (ALUOp),
        .reg_write  (reg_write),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .jump       (jump),
        .illegal    (illegal)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table
    function automatic logic [9:0] exp_ctrl(input logic v, input logic [6:0] op);
        logic [9:0] e;
        if (!v) begin
            e = 10'b00_0_0_0_0_0_0_0_0;
        end else begin
            case (op)
                7'b0110011: e = 10'b10_1_0_0_0_0_0_0_0;
                7'b0010011: e = 10'b11_1_0_0_0_1_0_0_0;
                7'b0000011: e = 10'b00_1_0_1_0_1_1_0_0;
                7'b0100011: e = 10'b00_0_0_0_1_1_0_0_0;
                7'b1100011: e = 10'b01_0_1_0_0_0_0_0_0;
                7'b1101111: e = 10'b00_1_0_0_0_0_0_1_0;
                7'b1100111: e = 10'b00_1_0_0_0_1_0_1_0;
                7'b0010111: e = 10'b00_1_0_0_0_1_0_0_0;
                7'b0110111: e = 10'b00_1_0_0_0_1_0_0_0;
                default:    e = 10'b00_0_0_0_0_0_0_0_1;
            endcase
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge capture, check at the next negedge
    task automatic step(input string tag, input logic v, input logic [6:0] op);
        valid_in = v;
        opcode   = op;
        @(negedge clk);
        check_val(tag, obs_s, exp_ctrl(v, op));
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] sweep_ops [7];

    initial begin
        logic [6:0] op;
        logic       v;
        n_compared   = 0;
        n_mismatched = 0;
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};
        sweep_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b0010111};

        // Reset held with a legal R-type presented
        rst_n    = 1'b0;
        valid_in = 1'b1;
        opcode   = 7'b0110011;
        repeat (3) @(negedge clk);
        check_val("reset_hold", obs_s, 10'b0);

        // Release: first capture on the next rising edge
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_release_r", obs_s, 10'b10_1_0_0_0_0_0_0_0);

        // Opcode sweep, one per cycle
        foreach (sweep_ops[i]) step("sweep", 1'b1, sweep_ops[i]);
        step("jalr", 1'b1, 7'b1100111);
        step("lui", 1'b1, 7'b0110111);

        // Unknown opcode, then a legal one clears illegal
        step("illegal_7f", 1'b1, 7'b1111111);
        check_val("illegal_flag", {9'b0, illegal}, 10'b1);
        step("illegal_clear", 1'b1, 7'b0110011);
        step("illegal_00", 1'b1, 7'b0000000);

        // Bubble with a store opcode
        step("bubble_store", 1'b0, 7'b0100011);
        step("bubble_illegal_op", 1'b0, 7'b1111111);

        // Async reset between edges while load controls are showing
        step("pre_async_load", 1'b1, 7'b0000011);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_clear", obs_s, 10'b0);
        @(negedge clk);
        check_val("async_reset_hold", obs_s, 10'b0);
        rst_n = 1'b1;
        step("post_async_store", 1'b1, 7'b0100011);

        // Random opcodes / valid_in against the table, plus invariants
        for (int k = 0; k < 1000; k++) begin
            v = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0) begin
                op = legal_ops[$urandom_range(0, 8)];
            end else begin
                op = 7'($urandom_range(0, 127));
            end
            step("random", v, op);
            check_val("inv_rd_wr", {9'b0, mem_read & mem_write}, 10'b0);
            check_val("inv_rw_mw", {9'b0, reg_write & mem_write}, 10'b0);
            check_val("inv_rw_br", {9'b0, reg_write & branch}, 10'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
